// File: rtl/frame_buf_pkg.sv
// Shared definitions for the triple-buffered frame store.
// Holds the frame geometry defaults, the bank-code width, the reset bank
// assignment for the write/ready/read roles and the capture FSM state type.
// No ports; imported by frame_bank_scheduler and triple_bank_rotator.
package frame_buf_pkg;

  localparam int ADDR_W       = 19;
  localparam int BANK_W       = 2;
  localparam int FRAME_PIXELS = 307200;

  localparam logic [BANK_W-1:0] BANK_W_RST = 2'd0;
  localparam logic [BANK_W-1:0] BANK_Y_RST = 2'd1;
  localparam logic [BANK_W-1:0] BANK_R_RST = 2'd2;

  typedef enum logic {
    SEEK    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

endpackage

// File: rtl/triple_bank_rotator.sv
// Role register file for three frame banks: write (w), ready (y), read (r),
// plus the "fresh" flag meaning y holds a completed frame not yet shown.
// Ports:
//   clk25, rst_n          clock, async active-low reset
//   commit_req            a complete frame has just been written into w
//   swap_req              vsync edge: reader wants the newest frame
//   w_bank/y_bank/r_bank  current role assignment (always a permutation of 0..2)
//   fresh                 y holds an unseen frame
//   drop_evt              this cycle overwrites an unseen ready frame
//   show_evt              this cycle hands the reader a new bank
//   repeat_evt            this cycle's vsync re-shows the old frame
// All role changes are rotations or swaps of existing codes, so the three
// banks stay pairwise distinct and code 3 can never appear.
module triple_bank_rotator
  import frame_buf_pkg::*;
(
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              commit_req,
  input  logic              swap_req,
  output logic [BANK_W-1:0] w_bank,
  output logic [BANK_W-1:0] y_bank,
  output logic [BANK_W-1:0] r_bank,
  output logic              fresh,
  output logic              drop_evt,
  output logic              show_evt,
  output logic              repeat_evt
);

  assign drop_evt   = commit_req & fresh;
  // A simultaneous commit hands over the just-finished frame even if y was stale.
  assign show_evt   = swap_req & (fresh | commit_req);
  assign repeat_evt = swap_req & ~fresh & ~commit_req;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      w_bank <= BANK_W_RST;
      y_bank <= BANK_Y_RST;
      r_bank <= BANK_R_RST;
      fresh  <= 1'b0;
    end else if (commit_req && swap_req) begin
      // Three-way rotation: the frame just written goes straight to the reader.
      r_bank <= w_bank;
      w_bank <= y_bank;
      y_bank <= r_bank;
      fresh  <= 1'b0;
    end else if (commit_req) begin
      y_bank <= w_bank;
      w_bank <= y_bank;
      fresh  <= 1'b1;
    end else if (swap_req && fresh) begin
      r_bank <= y_bank;
      y_bank <= r_bank;
      fresh  <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler between the camera capture writer and the VGA
// scanout reader. Capture writes are steered into the write bank; complete
// frames are promoted to ready; at each vsync the reader takes the newest
// complete frame, so scanout never shows a torn frame.
// Optional build macro FRAME_SCHED_STATS_EN enables the drop/repeat
// statistics counters; without it both outputs are tied to 0.
// Ports:
//   clk25, rst_n                  pixel clock, async active-low reset
//   cap_frame_start/cap_frame_end camera frame boundary pulses
//   cap_we, cap_addr              capture pixel strobe and address
//   wr_en, wr_addr                registered memory write {wr_bank, cap_addr}
//   vga_vsync, frame_addr         VGA vertical sync and read address
//   rd_addr                       combinational {rd_bank, frame_addr}
//   wr_bank, rd_bank              current write and read banks
//   new_frame                     one-cycle pulse when the read bank changes
//   drop_cnt, repeat_cnt          saturating statistics
module frame_bank_scheduler #(
  parameter int   ADDR_W       = frame_buf_pkg::ADDR_W,
  parameter int   FRAME_PIXELS = frame_buf_pkg::FRAME_PIXELS,
  parameter logic VSYNC_ACTIVE = 1'b0,
  parameter int   STAT_W       = 16
) (
  input  logic                              clk25,
  input  logic                              rst_n,
  input  logic                              cap_frame_start,
  input  logic                              cap_frame_end,
  input  logic                              cap_we,
  input  logic [ADDR_W-1:0]                 cap_addr,
  output logic                              wr_en,
  output logic [ADDR_W+1:0]                 wr_addr,
  input  logic                              vga_vsync,
  input  logic [ADDR_W-1:0]                 frame_addr,
  output logic [ADDR_W+1:0]                 rd_addr,
  output logic [frame_buf_pkg::BANK_W-1:0]  wr_bank,
  output logic [frame_buf_pkg::BANK_W-1:0]  rd_bank,
  output logic                              new_frame,
  output logic [STAT_W-1:0]                 drop_cnt,
  output logic [STAT_W-1:0]                 repeat_cnt
);
  import frame_buf_pkg::*;

  localparam int                CNT_W  = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0]  FP_MAX = CNT_W'(FRAME_PIXELS);

  cap_state_t         state;
  logic [CNT_W-1:0]   pix_cnt;
  logic               vsync_prev;
  logic               commit_req;
  logic               swap_req;
  logic [BANK_W-1:0]  y_bank;
  logic               fresh;
  logic               drop_evt;
  logic               show_evt;
  logic               repeat_evt;

  // A restart pulse in the same cycle as an end pulse wins: no commit.
  assign commit_req = (state == CAPTURE) && cap_frame_end && !cap_frame_start &&
                      (pix_cnt == FP_MAX);
  assign swap_req   = (vga_vsync == VSYNC_ACTIVE) && (vsync_prev != VSYNC_ACTIVE);

  triple_bank_rotator u_rot (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .commit_req (commit_req),
    .swap_req   (swap_req),
    .w_bank     (wr_bank),
    .y_bank     (y_bank),
    .r_bank     (rd_bank),
    .fresh      (fresh),
    .drop_evt   (drop_evt),
    .show_evt   (show_evt),
    .repeat_evt (repeat_evt)
  );

  assign rd_addr = {rd_bank, frame_addr};

  // Capture FSM with registered write port.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SEEK;
      pix_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      case (state)
        SEEK: begin
          wr_en <= 1'b0;
          if (cap_frame_start) begin
            state   <= CAPTURE;
            pix_cnt <= '0;
          end
        end
        CAPTURE: begin
          wr_en   <= cap_we;
          wr_addr <= {wr_bank, cap_addr};
          if (cap_frame_start) begin
            pix_cnt <= '0;
          end else if (cap_frame_end) begin
            state <= SEEK;
          end else if (cap_we && (pix_cnt != FP_MAX)) begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end
        default: state <= SEEK;
      endcase
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev <= ~VSYNC_ACTIVE;
      new_frame  <= 1'b0;
    end else begin
      vsync_prev <= vga_vsync;
      new_frame  <= show_evt;
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  logic [STAT_W-1:0] drop_q;
  logic [STAT_W-1:0] rep_q;

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      rep_q  <= '0;
    end else begin
      if (drop_evt && !(&drop_q)) drop_q <= drop_q + 1'b1;
      if (repeat_evt && !(&rep_q)) rep_q <= rep_q + 1'b1;
    end
  end

  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;
`else
  logic unused_stats;
  assign unused_stats = drop_evt | repeat_evt;
  assign drop_cnt     = '0;
  assign repeat_cnt   = '0;
`endif

  // y_bank and fresh are kept visible for debug only.
  logic unused_dbg;
  assign unused_dbg = ^{y_bank, fresh};

endmodule

// File: tb/tb_frame_bank_scheduler.sv
module tb_frame_bank_scheduler;
  localparam int AW = 19;
  localparam int FP = 64;
  localparam int SW = 16;

  logic          clk25 = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_frame_start = 1'b0;
  logic          cap_frame_end = 1'b0;
  logic          cap_we = 1'b0;
  logic [AW-1:0] cap_addr = '0;
  logic          wr_en;
  logic [AW+1:0] wr_addr;
  logic          vga_vsync = 1'b1;
  logic [AW-1:0] frame_addr = '0;
  logic [AW+1:0] rd_addr;
  logic [1:0]    wr_bank;
  logic [1:0]    rd_bank;
  logic          new_frame;
  logic [SW-1:0] drop_cnt;
  logic [SW-1:0] repeat_cnt;

  frame_bank_scheduler #(
    .ADDR_W(AW), .FRAME_PIXELS(FP), .VSYNC_ACTIVE(1'b0), .STAT_W(SW)
  ) dut (
    .clk25(clk25), .rst_n(rst_n),
    .cap_frame_start(cap_frame_start), .cap_frame_end(cap_frame_end),
    .cap_we(cap_we), .cap_addr(cap_addr),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .vga_vsync(vga_vsync), .frame_addr(frame_addr), .rd_addr(rd_addr),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .new_frame(new_frame),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  // clock / reset
  always #5 clk25 = ~clk25;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int failures = 0;

  // scoreboard of expected memory writes
  logic [AW+1:0] exp_q[$];

  // reference model of bank roles
  int mw, my, mr;
  bit mfresh;
  int mdrop, mrep;
  bit mcap;
  int mcnt;
  int nf_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    mw = 0; my = 1; mr = 2; mfresh = 0; mdrop = 0; mrep = 0; mcap = 0; mcnt = 0;
  endfunction

  function automatic void m_step(bit commit, bit swap);
    int tw, ty, tr;
    tw = mw; ty = my; tr = mr;
    if (commit && swap) begin
      if (mfresh) mdrop++;
      mr = tw; mw = ty; my = tr; mfresh = 0;
    end else if (commit) begin
      if (mfresh) mdrop++;
      my = tw; mw = ty; mfresh = 1;
    end else if (swap) begin
      if (mfresh) begin
        mr = ty; my = tr; mfresh = 0;
      end else begin
        mrep++;
      end
    end
  endfunction

  function automatic int exp_stat(int v);
`ifdef FRAME_SCHED_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic start_f();
    cap_frame_start = 1'b1;
    mcap = 1; mcnt = 0;
    tick();
    cap_frame_start = 1'b0;
  endtask

  task automatic pix(input int a);
    logic [1:0] b;
    cap_we = 1'b1;
    cap_addr = AW'(a);
    if (mcap) begin
      b = mw[1:0];
      exp_q.push_back({b, cap_addr});
      if (mcnt < FP) mcnt++;
    end
    tick();
    cap_we = 1'b0;
  endtask

  // with_vs drives the vsync edge in the same cycle as the frame end
  task automatic end_f(input bit with_vs);
    bit commit;
    commit = mcap && (mcnt == FP);
    mcap = 0;
    cap_frame_end = 1'b1;
    if (with_vs) vga_vsync = 1'b0;
    m_step(commit, with_vs);
    tick();
    cap_frame_end = 1'b0;
  endtask

  task automatic vs_edge();
    vga_vsync = 1'b0;
    m_step(0, 1);
    tick();
  endtask

  task automatic vs_release();
    vga_vsync = 1'b1;
    tick();
  endtask

  task automatic full_frame();
    start_f();
    for (int i = 0; i < FP; i++) pix(i);
    end_f(0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'(mw));
    chk({tag, "_rd_bank"}, 32'(rd_bank), 32'(mr));
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(exp_stat(mdrop)));
    chk({tag, "_repeat"}, 32'(repeat_cnt), 32'(exp_stat(mrep)));
  endtask

  // scoreboard monitor: pops one expected write per observed write
  always @(negedge clk25) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'(wr_en), 32'd0);
        end else begin
          chk("wr_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
        end
      end
      if (new_frame) nf_seen++;
    end
  end

  initial begin
    m_reset();
    nf_seen = 0;
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_new_frame", 32'(new_frame), 32'd0);
    chk_state("rst");
    frame_addr = AW'(7);
    #1;
    chk("rst_rd_addr", 32'(rd_addr), 32'({2'd2, 19'd7}));
    @(negedge clk25);
    rst_n = 1'b1;
    tick();

    // T1: complete frame then vsync hands it to the reader
    full_frame();
    tick();
    chk_state("t1_commit");
    vs_edge();
    chk("t1_new_frame", 32'(new_frame), 32'd1);
    chk_state("t1_swap");
    frame_addr = AW'(5);
    #1;
    chk("t1_rd_addr", 32'(rd_addr), 32'({2'd0, 19'd5}));
    vs_release();
    chk("t1_new_frame_end", 32'(new_frame), 32'd0);

    // T2: short frame is discarded, vsync repeats the old frame
    start_f();
    for (int i = 0; i < 20; i++) pix(i);
    end_f(0);
    tick();
    chk_state("t2_discard");
    vs_edge();
    chk("t2_new_frame", 32'(new_frame), 32'd0);
    chk_state("t2_swap");
    vs_release();

    // T3: restart without end, then two committed frames before vsync
    start_f();
    for (int i = 0; i < 10; i++) pix(i);
    full_frame();
    chk_state("t3_first");
    full_frame();
    tick();
    chk_state("t3_second");
    vs_edge();
    chk("t3_new_frame", 32'(new_frame), 32'd1);
    chk_state("t3_swap");
    vs_release();

    // T4: commit in the same cycle as the vsync edge while fresh
    full_frame();
    start_f();
    for (int i = 0; i < FP; i++) pix($urandom_range(0, 307199));
    nf_seen = 0;
    end_f(1);
    chk("t4_new_frame", 32'(new_frame), 32'd1);
    chk_state("t4_sim");
    vs_release();
    tick();
    tick();
    chk("t4_single_pulse", 32'(nf_seen), 32'd1);
    chk("t4_distinct", 32'(wr_bank != rd_bank), 32'd1);

    // T5: reset in the middle of a capture
    start_f();
    for (int i = 0; i < FP / 2; i++) pix(i);
    chk("t5_wr_en_pre", 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_reset();
    chk("t5_wr_en_async", 32'(wr_en), 32'd0);
    chk_state("t5_rst");
    @(negedge clk25);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) pix(i);
    end_f(0);
    chk("t5_wr_en_ignored", 32'(wr_en), 32'd0);
    chk_state("t5_seek");
    full_frame();
    tick();
    chk_state("t5_commit");

    tick();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
